// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scan controller
// with ghost-guard blanking, 16-level PWM and frame-atomic updates.
module seg_scan_ctrl #(
   parameter int DWELL_LOG2 = 9,
   parameter int GUARD      = 8
) (
   input  logic       CLKIN,
   input  logic       RESET_N,
   input  logic       ENABLE,
   input  logic       LOAD,
   input  logic [7:0] DIG0,
   input  logic [7:0] DIG1,
   input  logic [7:0] DIG2,
   input  logic [7:0] DIG3,
   input  logic [3:0] DIG_EN,
   input  logic [3:0] BRIGHT,
   output logic [7:0] SEG,
   output logic [3:0] SEL,
   output logic       FRAME_DONE,
   output logic       BUSY
);

   localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
   localparam int CW = (DWELL_LOG2 > GW) ? DWELL_LOG2 : GW;
   localparam logic [CW-1:0] G_LAST  = CW'(GUARD - 1);
   localparam logic [CW-1:0] ON_LAST = CW'((2 ** DWELL_LOG2) - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GUARD,
      S_ON
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            xfer;
   logic            fd_d;
   logic            lit;
   logic [7:0]      seg_d;
   logic [3:0]      sel_d;

   logic [3:0][7:0] pend_pat_q, act_pat_q, act_pat_d;
   logic [3:0]      pend_en_q, act_en_q, act_en_d;
   logic [3:0]      pend_br_q, act_br_q, act_br_d;

   // Pending buffer: every LOAD overwrites, last one before a transfer wins.
   always_ff @(posedge CLKIN or negedge RESET_N) begin
      if (!RESET_N) begin
         pend_pat_q <= {4{8'hFF}};
         pend_en_q  <= 4'h0;
         pend_br_q  <= 4'h0;
      end else if (LOAD) begin
         pend_pat_q <= {DIG3, DIG2, DIG1, DIG0};
         pend_en_q  <= DIG_EN;
         pend_br_q  <= BRIGHT;
      end
   end

   // Next state, frame-start transfer and registered output values.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      xfer    = 1'b0;
      fd_d    = 1'b0;
      if (!ENABLE) begin
         state_d = S_IDLE;
         idx_d   = 2'd0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_GUARD;
               idx_d   = 2'd0;
               cnt_d   = '0;
               xfer    = 1'b1;
            end
            S_GUARD: begin
               if (cnt_q == G_LAST) begin
                  state_d = S_ON;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_ON: begin
               if (cnt_q == ON_LAST) begin
                  state_d = S_GUARD;
                  cnt_d   = '0;
                  if (idx_q == 2'd3) begin
                     idx_d = 2'd0;
                     fd_d  = 1'b1;
                     xfer  = 1'b1;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               idx_d   = 2'd0;
               cnt_d   = '0;
            end
         endcase
      end

      act_pat_d = xfer ? pend_pat_q : act_pat_q;
      act_en_d  = xfer ? pend_en_q  : act_en_q;
      act_br_d  = xfer ? pend_br_q  : act_br_q;

      lit = (state_d == S_ON) && act_en_d[idx_d]
            && (cnt_d[DWELL_LOG2-1 -: 4] <= act_br_d);
      sel_d = lit ? ~(4'b0001 << idx_d) : 4'hF;
      seg_d = lit ? act_pat_d[idx_d] : 8'hFF;
   end

   // State, active buffer and output registers.
   always_ff @(posedge CLKIN or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         idx_q      <= 2'd0;
         cnt_q      <= '0;
         act_pat_q  <= {4{8'hFF}};
         act_en_q   <= 4'h0;
         act_br_q   <= 4'h0;
         SEG        <= 8'hFF;
         SEL        <= 4'hF;
         FRAME_DONE <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         act_pat_q  <= act_pat_d;
         act_en_q   <= act_en_d;
         act_br_q   <= act_br_d;
         SEG        <= seg_d;
         SEL        <= sel_d;
         FRAME_DONE <= fd_d;
         BUSY       <= (state_d != S_IDLE);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: random and directed stimulus against a
// frame-time reference model of the scan controller.
module tb_seg_scan_ctrl;

   localparam int G     = 2;
   localparam int DL    = 4;
   localparam int S     = 1 << DL;
   localparam int SLOT  = G + S;
   localparam int FRAME = 4 * SLOT;

   logic       CLKIN = 1'b0;
   logic       RESET_N = 1'b1;
   logic       ENABLE = 1'b0;
   logic       LOAD = 1'b0;
   logic [7:0] DIG0 = 8'h00;
   logic [7:0] DIG1 = 8'h00;
   logic [7:0] DIG2 = 8'h00;
   logic [7:0] DIG3 = 8'h00;
   logic [3:0] DIG_EN = 4'h0;
   logic [3:0] BRIGHT = 4'h0;
   logic [7:0] SEG;
   logic [3:0] SEL;
   logic       FRAME_DONE;
   logic       BUSY;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] m_pend [4];
   logic [7:0] m_act  [4];
   logic [3:0] m_pend_en, m_act_en, m_pend_br, m_act_br;
   logic       m_run;
   int         m_t;
   logic       m_fd;

   seg_scan_ctrl #(.DWELL_LOG2(DL), .GUARD(G)) dut (
      .CLKIN(CLKIN), .RESET_N(RESET_N), .ENABLE(ENABLE), .LOAD(LOAD),
      .DIG0(DIG0), .DIG1(DIG1), .DIG2(DIG2), .DIG3(DIG3),
      .DIG_EN(DIG_EN), .BRIGHT(BRIGHT),
      .SEG(SEG), .SEL(SEL), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
   );

   always #5 CLKIN = ~CLKIN;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h",
                  tag, $time, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_pend[i] = 8'hFF;
         m_act[i]  = 8'hFF;
      end
      m_pend_en = 4'h0;
      m_act_en  = 4'h0;
      m_pend_br = 4'h0;
      m_act_br  = 4'h0;
      m_run = 1'b0;
      m_t   = 0;
      m_fd  = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      int slot, off, c;
      logic lit;
      logic [3:0] e_sel;
      logic [7:0] e_seg;
      e_sel = 4'hF;
      e_seg = 8'hFF;
      if (m_run) begin
         slot = m_t / SLOT;
         off  = m_t % SLOT;
         if (off >= G) begin
            c   = off - G;
            lit = m_act_en[slot] && ((c * 16) / S <= int'(m_act_br));
            if (lit) begin
               e_sel = 4'hF;
               e_sel[slot] = 1'b0;
               e_seg = m_act[slot];
            end
         end
      end
      chk({tag, ".sel"}, 32'(SEL), 32'(e_sel));
      chk({tag, ".seg"}, 32'(SEG), 32'(e_seg));
      chk({tag, ".fd"}, 32'(FRAME_DONE), 32'(m_fd));
      chk({tag, ".busy"}, 32'(BUSY), 32'(m_run));
   endtask

   task automatic step(input string tag, input logic en, input logic ld,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3,
                       input logic [3:0] e, input logic [3:0] b);
      ENABLE = en;
      LOAD   = ld;
      DIG0 = d0; DIG1 = d1; DIG2 = d2; DIG3 = d3;
      DIG_EN = e;
      BRIGHT = b;
      @(posedge CLKIN);
      m_fd = 1'b0;
      if (!en) begin
         m_run = 1'b0;
         m_t   = 0;
      end else if (!m_run) begin
         m_run = 1'b1;
         m_t   = 0;
         m_act = m_pend;
         m_act_en = m_pend_en;
         m_act_br = m_pend_br;
      end else begin
         m_t++;
         if (m_t == FRAME) begin
            m_t  = 0;
            m_fd = 1'b1;
            m_act = m_pend;
            m_act_en = m_pend_en;
            m_act_br = m_pend_br;
         end
      end
      if (ld) begin
         m_pend[0] = d0; m_pend[1] = d1;
         m_pend[2] = d2; m_pend[3] = d3;
         m_pend_en = e;
         m_pend_br = b;
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic idle_step(input string tag, input logic en);
      step(tag, en, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0);
   endtask

   task automatic rand_step(input string tag, input int p_off,
                            input int p_ld);
      logic en, ld;
      en = ($urandom_range(0, p_off - 1) != 0);
      ld = ($urandom_range(0, p_ld - 1) == 0);
      step(tag, en, ld, 8'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), 4'($urandom), 4'($urandom));
   endtask

   initial begin
      model_reset();
      #2 RESET_N = 1'b0;
      #1 check_outputs("reset");
      #10 RESET_N = 1'b1;

      for (int i = 0; i < 30; i++)
         step("idle", 1'b0, 1'($urandom_range(0, 1)), 8'h12, 8'h34,
              8'h56, 8'h78, 4'hF, 4'hF);

      step("ld_basic", 1'b0, 1'b1, 8'hC0, 8'hF9, 8'hA4, 8'hB0,
           4'hF, 4'hF);
      for (int i = 0; i < 3 * FRAME; i++) idle_step("basic", 1'b1);

      step("ld_pwm3", 1'b1, 1'b1, 8'hC0, 8'hF9, 8'hA4, 8'hB0,
           4'b0101, 4'd3);
      for (int i = 0; i < 2 * FRAME; i++) idle_step("pwm3", 1'b1);
      step("ld_pwm0", 1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44,
           4'hF, 4'd0);
      for (int i = 0; i < 2 * FRAME; i++) idle_step("pwm0", 1'b1);

      // Load a new digit-1 pattern mid-slot of digit 1.
      while (m_t != SLOT + G + 5) idle_step("align", 1'b1);
      step("ld_mid", 1'b1, 1'b1, 8'h11, 8'h99, 8'h33, 8'h44,
           4'hF, 4'hF);
      for (int i = 0; i < 2 * FRAME; i++) idle_step("mid", 1'b1);

      // Load on the last cycle before frame start: it lands on the
      // transfer edge, so it must wait one more frame.
      while (m_t != FRAME - 1) idle_step("align2", 1'b1);
      step("ld_edge", 1'b1, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04,
           4'hF, 4'hF);
      for (int i = 0; i < 2 * FRAME; i++) idle_step("edge", 1'b1);

      // Abort during digit 2 ON, then re-enable.
      while (m_t != 2 * SLOT + G + 3) idle_step("align3", 1'b1);
      idle_step("abort", 1'b0);
      idle_step("abort2", 1'b0);
      for (int i = 0; i < FRAME; i++) idle_step("reen", 1'b1);

      for (int i = 0; i < 3000; i++) rand_step("rand", 150, 25);

      // Asynchronous reset mid-scan.
      while (!(m_run && (m_t % SLOT) == G + 4)) idle_step("align4", 1'b1);
      #3 RESET_N = 1'b0;
      model_reset();
      #1 check_outputs("async_rst");
      @(posedge CLKIN);
      #1 check_outputs("in_rst");
      RESET_N = 1'b1;
      for (int i = 0; i < FRAME + 10; i++) idle_step("post_rst", 1'b1);

      for (int i = 0; i < 1500; i++) rand_step("rand2", 60, 10);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
